fpga_cfg_loader: RTL and testbench

FPGA_CFG_LOADER -- requirements
Module: fpga_cfg_loader

---
 rtl/fpga_cfg_loader.sv | 149 ++++++++++++++
 tb/tb_fpga_cfg_loader.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/fpga_cfg_loader.sv
// Serial configuration-chain loader: optional chain-length self-test (flush + marker),
// then streams a byte-wide bitstream MSB-first into ccff_head with a gated prog_clk.
module fpga_cfg_loader #(
  parameter int CHAIN_LEN = 512
) (
  input  logic       prog_clk,
  input  logic       reset,
  input  logic       start,
  input  logic       check_en,
  input  logic [7:0] cfg_data,
  input  logic       cfg_valid,
  output logic       cfg_ready,
  output logic       ccff_head,
  input  logic       ccff_tail,
  output logic       prog_clk_en,
  output logic       busy,
  output logic       done,
  output logic       chk_err
);

  localparam int CW = $clog2(CHAIN_LEN + 1);
  localparam int NB = (CHAIN_LEN + 7) / 8;
  localparam logic [CW-1:0] LEN    = CW'(CHAIN_LEN);
  localparam logic [CW-1:0] LEN_M1 = CW'(CHAIN_LEN - 1);
  localparam logic [CW-1:0] NBYTES = CW'(NB);

  typedef enum logic [2:0] {IDLE, FLUSH, MARK, LOAD, DONE} state_t;

  typedef struct packed {
    logic [7:0] sr;
    logic [3:0] sr_cnt;
    logic [7:0] hold;
    logic       hold_vld;
  } dp_t;

  state_t        state, st_n;
  logic [CW-1:0] cnt, cnt_n, cnt_inc;
  logic [CW-1:0] byte_cnt, bc_n;
  dp_t           dp, dp_n;
  logic          head_n, pen_n, err_n;

  // cnt tracks shifts already taken by the fabric (a shift lands on every edge with prog_clk_en=1)
  assign cnt_inc   = cnt + CW'(prog_clk_en);
  assign cfg_ready = (state == LOAD) && !dp.hold_vld && (byte_cnt < NBYTES);
  assign busy      = (state == FLUSH) || (state == MARK) || (state == LOAD);
  assign done      = (state == DONE);

  always_ff @(posedge prog_clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      byte_cnt    <= '0;
      dp          <= '0;
      ccff_head   <= 1'b0;
      prog_clk_en <= 1'b0;
      chk_err     <= 1'b0;
    end else begin
      state       <= st_n;
      cnt         <= cnt_n;
      byte_cnt    <= bc_n;
      dp          <= dp_n;
      ccff_head   <= head_n;
      prog_clk_en <= pen_n;
      chk_err     <= err_n;
    end
  end

  always_comb begin
    st_n   = state;
    cnt_n  = cnt;
    bc_n   = byte_cnt;
    dp_n   = dp;
    head_n = ccff_head;
    pen_n  = 1'b0;
    err_n  = chk_err;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          err_n  = 1'b0;
          cnt_n  = '0;
          bc_n   = '0;
          dp_n   = '0;
          head_n = 1'b0;
          if (check_en) begin
            st_n  = FLUSH;
            pen_n = 1'b1;
          end else begin
            st_n  = LOAD;
          end
        end
      end
      FLUSH: begin
        cnt_n  = cnt_inc;
        head_n = 1'b0;
        pen_n  = 1'b1;
        if (prog_clk_en && cnt == LEN_M1) begin
          st_n   = MARK;
          cnt_n  = '0;
          head_n = 1'b1;
        end
      end
      MARK: begin
        // marker goes in on the first shift; stop shifting once LEN shifts are issued
        cnt_n  = cnt_inc;
        head_n = 1'b0;
        pen_n  = (cnt_inc < LEN);
        if (cnt != '0 && ccff_tail) begin
          pen_n = 1'b0;
          if (cnt == LEN) begin
            st_n  = LOAD;
            cnt_n = '0;
          end else begin
            err_n = 1'b1;
            st_n  = DONE;
          end
        end else if (cnt == LEN) begin
          err_n = 1'b1;
          st_n  = DONE;
        end
      end
      LOAD: begin
        if (cfg_valid && cfg_ready) begin
          dp_n.hold     = cfg_data;
          dp_n.hold_vld = 1'b1;
          bc_n          = byte_cnt + CW'(1);
        end
        if (cnt == LEN) begin
          st_n = DONE;
        end else if (dp.sr_cnt != 4'd0) begin
          head_n      = dp.sr[7];
          dp_n.sr     = {dp.sr[6:0], 1'b0};
          dp_n.sr_cnt = dp.sr_cnt - 4'd1;
          pen_n       = 1'b1;
          cnt_n       = cnt + CW'(1);
        end else if (dp.hold_vld) begin
          // refill and emit the new MSB in the same cycle so streaming is gap-free
          head_n        = dp.hold[7];
          dp_n.sr       = {dp.hold[6:0], 1'b0};
          dp_n.sr_cnt   = 4'd7;
          dp_n.hold_vld = 1'b0;
          pen_n         = 1'b1;
          cnt_n         = cnt + CW'(1);
        end
      end
      default: st_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_fpga_cfg_loader.sv
// Bench for fpga_cfg_loader with a 20-bit fabric model (length selectable 19/20/21).
module tb_fpga_cfg_loader;
  localparam int N = 20;

  logic       prog_clk = 1'b0;
  logic       reset = 1'b0, start = 1'b0, check_en = 1'b0, cfg_valid = 1'b0;
  logic [7:0] cfg_data = 8'h00;
  logic       cfg_ready, ccff_head, ccff_tail, prog_clk_en, busy, done, chk_err;

  int n_chk = 0, n_err = 0;
  logic [31:0] chain = '0;
  int sh_cnt = 0;
  int model_len = N;

  // session results
  int acc_o, shifts_o, first_o, gap_left_o;
  bit to_o, abort_o;
  logic st_done, st_err, st_busy;

  always #5 prog_clk = ~prog_clk;

  fpga_cfg_loader #(.CHAIN_LEN(N)) dut (
    .prog_clk(prog_clk), .reset(reset), .start(start), .check_en(check_en),
    .cfg_data(cfg_data), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .ccff_head(ccff_head), .ccff_tail(ccff_tail), .prog_clk_en(prog_clk_en),
    .busy(busy), .done(done), .chk_err(chk_err)
  );

  // fabric: shift register on the gated clock
  always @(posedge prog_clk) begin
    if (prog_clk_en) begin
      chain  <= {chain[30:0], ccff_head};
      sh_cnt <= sh_cnt + 1;
    end
  end
  always_comb ccff_tail = chain[5'(model_len - 1)];

  task automatic check(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // reference: first N bits of the byte stream, MSB first, first bit ends at the tail
  function automatic logic [19:0] ref_chain(input logic [7:0] b0, b1, b2);
    logic [23:0] s;
    s = {b0, b1, b2};
    return s[23:4];
  endfunction

  task automatic session(input bit chk, input logic [7:0] b0, b1, b2,
                         input bit throttle, input bit gap, input int abort_at,
                         input int restart_at);
    logic [7:0] bq [4];
    int idx, base, post, gap_left;
    bit will_acc, fin;
    logic prev_head;
    bq[0] = b0; bq[1] = b1; bq[2] = b2; bq[3] = 8'h55;
    idx = 0; post = 0; gap_left = 5; will_acc = 0; fin = 0; prev_head = 1'b0;
    acc_o = 0; first_o = -1; to_o = 0; abort_o = 0;
    @(negedge prog_clk);
    base = sh_cnt;
    start = 1'b1; check_en = chk;
    @(negedge prog_clk);
    start = 1'b0; check_en = 1'b0;
    st_done = done; st_err = chk_err; st_busy = busy;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (will_acc) begin acc_o++; idx++; end
      if (first_o < 0 && sh_cnt - base > N && ccff_tail === 1'b1) first_o = sh_cnt - base;
      if (abort_at > 0 && sh_cnt - base >= abort_at) begin
        reset = 1'b1;
        #1;
        check("abort_outs", {ccff_head, prog_clk_en, cfg_ready, busy, done, chk_err}, 0);
        abort_o = 1; fin = 1;
        break;
      end
      start = (cyc == restart_at);
      cfg_valid = 1'b0;
      if (idx < 4) begin
        if (gap && idx == 1 && gap_left > 0) begin
          // gap counted once the first byte has fully drained, so the stall is visible
          if (sh_cnt - base >= 8) begin
            check("gap_pen", prog_clk_en, 0);
            check("gap_head", ccff_head, prev_head);
            gap_left--;
          end
        end else if (!throttle || $urandom_range(0, 9) > 2) begin
          cfg_valid = 1'b1;
          cfg_data  = bq[idx];
        end
      end
      will_acc  = cfg_valid && cfg_ready;
      prev_head = ccff_head;
      if (done) post++;
      if (post > 4) begin fin = 1; break; end
      @(negedge prog_clk);
    end
    cfg_valid = 1'b0; start = 1'b0;
    to_o = !fin;
    gap_left_o = gap_left;
    shifts_o = sh_cnt - base;
  endtask

  task automatic check_end(input string tag, input bit exp_err, input int exp_acc,
                           input logic [19:0] exp_chain, input int exp_shifts, input int exp_first);
    check({tag, "_timeout"}, to_o, 0);
    check({tag, "_done"}, done, 1);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_ready"}, cfg_ready, 0);
    check({tag, "_chk_err"}, chk_err, exp_err);
    check({tag, "_acc"}, acc_o, exp_acc);
    if (!exp_err) check({tag, "_chain"}, chain[19:0], exp_chain);
    if (exp_shifts >= 0) check({tag, "_shifts"}, shifts_o, exp_shifts);
    if (exp_first > -2) check({tag, "_first1"}, first_o, exp_first);
  endtask

  typedef struct {
    bit         chk;
    int         len;
    logic [7:0] b0, b1, b2;
    bit         exp_err;
    int         exp_acc;
    logic [19:0] exp_chain;
    int         exp_shifts;
    int         exp_first;   // -2 = don't check, -1 = tail never seen 1 after the flush
  } vec_t;

  vec_t tbl [6];

  initial begin
    tbl[0] = '{0, 20, 8'hA5, 8'h3C, 8'hF0, 0, 3, 20'hA53CF, 20, -1};
    tbl[1] = '{1, 20, 8'hA5, 8'h3C, 8'hF0, 0, 3, 20'hA53CF, 60, 40};
    tbl[2] = '{1, 19, 8'hA5, 8'h3C, 8'hF0, 1, 0, 20'h00000, -1, -2};
    tbl[3] = '{1, 21, 8'hA5, 8'h3C, 8'hF0, 1, 0, 20'h00000, 40, -1};
    tbl[4] = '{0, 20, 8'h00, 8'hFF, 8'h0F, 0, 3, 20'h00FF0, 20, -1};
    tbl[5] = '{1, 20, 8'h12, 8'h34, 8'h56, 0, 3, 20'h12345, 60, 40};

    reset = 1'b1;
    #1;
    check("reset_outs", {ccff_head, prog_clk_en, cfg_ready, busy, done, chk_err}, 0);
    repeat (3) @(negedge prog_clk);
    reset = 1'b0;
    check("idle_outs", {ccff_head, prog_clk_en, cfg_ready, busy, done, chk_err}, 0);

    for (int i = 0; i < 6; i++) begin
      model_len = tbl[i].len;
      session(tbl[i].chk, tbl[i].b0, tbl[i].b1, tbl[i].b2, 0, 0, 0, -1);
      check_end($sformatf("vec%0d", i), tbl[i].exp_err, tbl[i].exp_acc, tbl[i].exp_chain,
                tbl[i].exp_shifts, tbl[i].exp_first);
    end
    model_len = N;

    // input gap: stall visible on prog_clk_en, final contents unchanged
    session(0, 8'hA5, 8'h3C, 8'hF0, 0, 1, 0, -1);
    check("gap_seen", gap_left_o, 0);
    check_end("gap", 0, 3, 20'hA53CF, 20, -1);

    // start while busy is ignored
    session(1, 8'hA5, 8'h3C, 8'hF0, 0, 0, 0, 10);
    check_end("busy_start", 0, 3, 20'hA53CF, 60, 40);

    // start in DONE clears done and chk_err on the same edge
    model_len = 19;
    session(1, 8'hA5, 8'h3C, 8'hF0, 0, 0, 0, -1);
    check_end("short", 1, 0, 20'h0, -1, -2);
    model_len = N;
    session(0, 8'h5A, 8'hC3, 8'h0F, 0, 0, 0, -1);
    check("restart_done", st_done, 0);
    check("restart_err", st_err, 0);
    check("restart_busy", st_busy, 1);
    check_end("restart", 0, 3, ref_chain(8'h5A, 8'hC3, 8'h0F), 20, -1);

    // reset mid-load aborts; next session loads cleanly
    begin
      int s0;
      session(0, 8'hA5, 8'h3C, 8'hF0, 0, 0, 10, -1);
      check("abort_hit", abort_o, 1);
      s0 = sh_cnt;
      repeat (3) @(negedge prog_clk);
      check("abort_noshift", sh_cnt, s0);
      check("abort_pen", prog_clk_en, 0);
      reset = 1'b0;
      @(negedge prog_clk);
      session(0, 8'h96, 8'h69, 8'hE1, 0, 0, 0, -1);
      check_end("post_abort", 0, 3, ref_chain(8'h96, 8'h69, 8'hE1), 20, -1);
    end

    // randomized sessions with throttled cfg_valid
    for (int r = 0; r < 8; r++) begin
      logic [7:0] b0, b1, b2;
      bit c;
      b0 = 8'($urandom); b1 = 8'($urandom); b2 = 8'($urandom);
      c = 1'($urandom);
      session(c, b0, b1, b2, 1, 0, 0, -1);
      check_end($sformatf("rnd%0d", r), 0, 3, ref_chain(b0, b1, b2), c ? 3 * N : N, c ? 2 * N : -1);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
